// File: rtl/fetch_stage_if.sv
// Instruction-memory port bundle for the fetch stage.
// master = fetch side (addr/req out), slave = memory side (ack/rdata out).
interface fetch_stage_if;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem request, IF/ID reg.
// Ports: clk, rst_n (async low), e_f stall enable, branch_taken/target
// redirect, imem (fetch_stage_if.master), ir1/pc1/valid1 IF/ID outputs,
// fetch_count delivery counter (built only with `define FETCH_STAT_EN).
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          e_f,
    input  logic          branch_taken,
    input  logic [31:0]   branch_target,
    fetch_stage_if.master imem,
    output logic [31:0]   ir1,
    output logic [31:0]   pc1,
    output logic          valid1,
    output logic [31:0]   fetch_count
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] buffer_q, buffer_d;
    logic [31:0] ir1_d, pc1_d;
    logic        valid1_d;
    logic        load;
    logic [31:0] target;

    assign target = {branch_target[31:2], 2'b00};

    // In DRAIN the stale request keeps its address while pc already
    // points at the redirect target.
    assign imem.imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign imem.imem_req  = rst_n && (state_q != HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            buffer_q     <= '0;
            ir1          <= '0;
            pc1          <= '0;
            valid1       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            buffer_q     <= buffer_d;
            ir1          <= ir1_d;
            pc1          <= pc1_d;
            valid1       <= valid1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        buffer_d     = buffer_q;
        ir1_d        = ir1;
        pc1_d        = pc1;
        valid1_d     = valid1;
        load         = 1'b0;

        if (branch_taken) begin
            ir1_d    = '0;
            valid1_d = 1'b0;
            pc_d     = target;
            unique case (state_q)
                FETCH: begin
                    if (!imem.imem_ack) begin
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end
                HOLD: state_d = FETCH;
                DRAIN: begin
                    if (imem.imem_ack) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem.imem_ack) begin
                        if (e_f) begin
                            ir1_d    = imem.imem_rdata;
                            pc1_d    = pc_q;
                            valid1_d = 1'b1;
                            pc_d     = pc_q + 32'd4;
                            load     = 1'b1;
                        end else begin
                            buffer_d = imem.imem_rdata;
                            state_d  = HOLD;
                        end
                    end else if (e_f) begin
                        ir1_d    = '0;
                        valid1_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (e_f) begin
                        ir1_d    = buffer_q;
                        pc1_d    = pc_q;
                        valid1_d = 1'b1;
                        pc_d     = pc_q + 32'd4;
                        load     = 1'b1;
                        state_d  = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem.imem_ack) begin
                        state_d = FETCH;
                    end
                    if (e_f) begin
                        ir1_d    = '0;
                        valid1_d = 1'b0;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

`ifdef FETCH_STAT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign fetch_count = count_q;
`else
    logic stat_unused;

    assign stat_unused = load;
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed table, corner sequences,
// and randomized traffic against an instruction-stream reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        e_f = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] ir1, pc1, fetch_count;
    logic        valid1;

    logic        e_f2 = 1'b0;
    logic        br2 = 1'b0;
    logic [31:0] tgt2 = '0;
    logic [31:0] ir1_b, pc1_b, cnt_b;
    logic        valid1_b;

    int n_chk = 0;
    int n_fail = 0;

    fetch_stage_if bus ();
    fetch_stage_if bus2 ();

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .e_f          (e_f),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem         (bus),
        .ir1          (ir1),
        .pc1          (pc1),
        .valid1       (valid1),
        .fetch_count  (fetch_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .e_f          (e_f2),
        .branch_taken (br2),
        .branch_target(tgt2),
        .imem         (bus2),
        .ir1          (ir1_b),
        .pc1          (pc1_b),
        .valid1       (valid1_b),
        .fetch_count  (cnt_b)
    );

    function automatic logic [31:0] mw(input logic [31:0] a);
        return a ^ 32'hA5A5A5A5;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        e;
        logic        br;
        logic [31:0] tgt;
        logic        ack;
        logic        req;
        logic [31:0] addr;
        logic [31:0] ir;
        logic [31:0] pc1;
        logic        v;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(
        input logic e, input logic br, input logic [31:0] tgt,
        input logic ack, input logic req, input logic [31:0] addr,
        input logic [31:0] ir, input logic [31:0] p, input logic v);
        vec_t t;
        t.e = e; t.br = br; t.tgt = tgt; t.ack = ack;
        t.req = req; t.addr = addr; t.ir = ir; t.pc1 = p; t.v = v;
        return t;
    endfunction

    // Reference model: tracks the program-order instruction stream.
    logic [31:0] m_next_pc, m_stale_addr, m_ir, m_pc1, m_cnt;
    logic        m_stale, m_v;
    logic [31:0] m_buf[$];

    function automatic logic [31:0] exp_cnt(input logic [31:0] c);
`ifdef FETCH_STAT_EN
        return c;
`else
        return (c == 32'hFFFF_FFFF) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic m_reset();
        m_next_pc = 32'h0; m_stale = 0; m_stale_addr = 0;
        m_ir = 0; m_pc1 = 0; m_v = 0; m_cnt = 0;
        m_buf.delete();
    endtask

    task automatic m_deliver(input logic [31:0] w);
        m_ir = w;
        m_pc1 = m_next_pc;
        m_v = 1;
        m_next_pc = m_next_pc + 32'd4;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    endtask

    task automatic m_step(input logic e, input logic br,
                          input logic [31:0] tgt, input logic ack,
                          input logic [31:0] rd);
        logic req_b, got;
        req_b = (m_buf.size() == 0);
        got = ack && req_b;
        if (br) begin
            m_ir = 0; m_v = 0;
            m_buf.delete();
            if (got) m_stale = 0;
            else if (req_b && !m_stale) begin
                m_stale = 1;
                m_stale_addr = m_next_pc;
            end
            m_next_pc = {tgt[31:2], 2'b00};
        end else if (m_stale) begin
            if (got) m_stale = 0;
            if (e) begin m_ir = 0; m_v = 0; end
        end else if (m_buf.size() != 0) begin
            if (e) m_deliver(m_buf.pop_front());
        end else if (got) begin
            if (e) m_deliver(rd);
            else m_buf.push_back(rd);
        end else if (e) begin
            m_ir = 0; m_v = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        e_f = 0; branch_taken = 0; branch_target = 0;
        bus.imem_ack = 0; bus.imem_rdata = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic e, br, ack;
        logic [31:0] tgt, rd;

        bus.imem_ack = 0; bus.imem_rdata = 0;
        bus2.imem_ack = 0; bus2.imem_rdata = 0;

        tbl[0]  = mk(1,0,0,1, 1,32'h4,  32'hA5A5A5A5,32'h0,1);
        tbl[1]  = mk(1,0,0,1, 1,32'h8,  32'hA5A5A5A1,32'h4,1);
        tbl[2]  = mk(1,0,0,1, 1,32'hC,  32'hA5A5A5AD,32'h8,1);
        tbl[3]  = mk(0,0,0,1, 0,32'hC,  32'hA5A5A5AD,32'h8,1);
        tbl[4]  = mk(0,0,0,1, 0,32'hC,  32'hA5A5A5AD,32'h8,1);
        tbl[5]  = mk(0,0,0,1, 0,32'hC,  32'hA5A5A5AD,32'h8,1);
        tbl[6]  = mk(1,0,0,0, 1,32'h10, 32'hA5A5A5A9,32'hC,1);
        tbl[7]  = mk(1,1,32'h103,0, 1,32'h10, 0,32'hC,0);
        tbl[8]  = mk(1,0,0,0, 1,32'h10, 0,32'hC,0);
        tbl[9]  = mk(1,0,0,1, 1,32'h100,0,32'hC,0);
        tbl[10] = mk(1,0,0,0, 1,32'h100,0,32'hC,0);
        tbl[11] = mk(1,0,0,1, 1,32'h104,32'hA5A5A4A5,32'h100,1);
        tbl[12] = mk(1,1,32'h50,0, 1,32'h104,0,32'h100,0);
        tbl[13] = mk(1,1,32'h200,0,1,32'h104,0,32'h100,0);
        tbl[14] = mk(0,1,32'h300,0,1,32'h104,0,32'h100,0);
        tbl[15] = mk(1,0,0,1, 1,32'h300,0,32'h100,0);
        tbl[16] = mk(1,0,0,1, 1,32'h304,32'hA5A5A6A5,32'h300,1);
        tbl[17] = mk(0,0,0,1, 0,32'h304,32'hA5A5A6A5,32'h300,1);
        tbl[18] = mk(0,1,32'h40,0, 1,32'h40,0,32'h300,0);
        tbl[19] = mk(1,1,32'h80,1, 1,32'h80,0,32'h300,0);
        tbl[20] = mk(1,0,0,1, 1,32'h84, 32'hA5A5A525,32'h80,1);

        // reset state, sampled while rst_n is low
        #12;
        chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_ir1", ir1, 32'h0);
        chk("rst_pc1", pc1, 32'h0);
        chk("rst_valid", {31'b0, valid1}, 32'h0);
        chk("rst_cnt", fetch_count, 32'h0);
        chk("rst_req2", {31'b0, bus2.imem_req}, 32'h0);
        chk("rst_addr2", bus2.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_req", {31'b0, bus.imem_req}, 32'h1);

        // PC wrap on the second instance
        e_f2 = 1; bus2.imem_ack = 1;
        bus2.imem_rdata = mw(bus2.imem_addr);
        @(posedge clk); @(negedge clk);
        chk("wrap_pc1a", pc1_b, 32'hFFFF_FFFC);
        chk("wrap_ir1a", ir1_b, 32'h5A5A5A59);
        chk("wrap_addr", bus2.imem_addr, 32'h0);
        bus2.imem_rdata = mw(bus2.imem_addr);
        @(posedge clk); @(negedge clk);
        chk("wrap_pc1b", pc1_b, 32'h0);
        chk("wrap_addr2", bus2.imem_addr, 32'h4);
`ifdef FETCH_STAT_EN
        chk("wrap_cnt", cnt_b, 32'd2);
`else
        chk("wrap_cnt", cnt_b, 32'd0);
`endif
        e_f2 = 0; bus2.imem_ack = 0;

        // directed table on the main instance
        for (int i = 0; i < 21; i++) begin
            e_f = tbl[i].e;
            branch_taken = tbl[i].br;
            branch_target = tbl[i].tgt;
            bus.imem_ack = tbl[i].ack;
            bus.imem_rdata = mw(bus.imem_addr);
            @(posedge clk); @(negedge clk);
            chk($sformatf("t%0d_req", i), {31'b0, bus.imem_req},
                {31'b0, tbl[i].req});
            chk($sformatf("t%0d_addr", i), bus.imem_addr, tbl[i].addr);
            chk($sformatf("t%0d_ir1", i), ir1, tbl[i].ir);
            chk($sformatf("t%0d_pc1", i), pc1, tbl[i].pc1);
            chk($sformatf("t%0d_v", i), {31'b0, valid1}, {31'b0, tbl[i].v});
        end
`ifdef FETCH_STAT_EN
        chk("tbl_cnt", fetch_count, 32'd7);
`else
        chk("tbl_cnt", fetch_count, 32'd0);
`endif

        // randomized traffic against the model
        do_reset();
        m_reset();
        for (int c = 0; c < 500; c++) begin
            e = ($urandom_range(0, 3) != 0);
            br = ($urandom_range(0, 7) == 0);
            tgt = $urandom;
            ack = bus.imem_req && ($urandom_range(0, 1) == 1);
            rd = $urandom;
            e_f = e; branch_taken = br; branch_target = tgt;
            bus.imem_ack = ack; bus.imem_rdata = rd;
            @(posedge clk);
            m_step(e, br, tgt, ack, rd);
            @(negedge clk);
            chk("rnd_req", {31'b0, bus.imem_req},
                {31'b0, m_buf.size() == 0});
            chk("rnd_addr", bus.imem_addr,
                m_stale ? m_stale_addr : m_next_pc);
            chk("rnd_ir1", ir1, m_ir);
            chk("rnd_pc1", pc1, m_pc1);
            chk("rnd_v", {31'b0, valid1}, {31'b0, m_v});
            chk("rnd_cnt", fetch_count, exp_cnt(m_cnt));
        end

        // async reset in the middle of DRAIN
        e_f = 1; branch_taken = 1; branch_target = 32'h1000;
        bus.imem_ack = 1; bus.imem_rdata = 32'h1234;
        @(posedge clk); @(negedge clk);
        branch_taken = 0; bus.imem_rdata = 32'hCAFE;
        @(posedge clk); @(negedge clk);
        chk("pre_pc1", pc1, 32'h1000);
        branch_taken = 1; branch_target = 32'h2000; bus.imem_ack = 0;
        @(posedge clk); @(negedge clk);
        branch_taken = 0;
        chk("drain_addr", bus.imem_addr, 32'h1004);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_req", {31'b0, bus.imem_req}, 32'h0);
        chk("ar_addr", bus.imem_addr, 32'h0);
        chk("ar_ir1", ir1, 32'h0);
        chk("ar_pc1", pc1, 32'h0);
        chk("ar_v", {31'b0, valid1}, 32'h0);
        chk("ar_cnt", fetch_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ar_rel_req", {31'b0, bus.imem_req}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded at reset.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 e_f  input  1  fetch-stage enable from the pipeline controller; low = IF/ID register holds.
REQ-005 branch_taken  input  1  single-cycle redirect request from a later stage.
REQ-006 branch_target  input  32  redirect address; bits [1:0] ignored and treated as 00.
REQ-007 imem_addr  output  32  instruction-memory word address, equal to the current fetch PC.
REQ-008 imem_req  output  1  instruction-memory request.
REQ-009 imem_ack  input  1  memory response strobe; imem_rdata valid this cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 ir1  output  32  IF/ID instruction register, feeds the decode stage and the pipeline controller.
REQ-012 pc1  output  32  PC of the instruction in ir1.
REQ-013 valid1  output  1  ir1 holds a real instruction; low = bubble.
REQ-014 fetch_count  output  32  count of delivered instructions (see Configuration).

Function
REQ-015 States: FETCH (imem_req=1), HOLD (word buffered, imem_req=0), DRAIN (imem_req=1, returned word discarded).
REQ-016 At most one outstanding request; imem_addr and imem_req stay stable from assertion until the imem_ack cycle.
REQ-017 FETCH, imem_ack=1, e_f=1: ir1<=imem_rdata, pc1<=pc, valid1<=1, pc<=pc+4; stay in FETCH (back-to-back fetches, one word per cycle at zero-wait memory).
REQ-018 FETCH, imem_ack=1, e_f=0: buffer<=imem_rdata; go to HOLD; ir1, pc1 and valid1 hold.
REQ-019 FETCH, imem_ack=0, e_f=1: ir1<=32'h0000_0000 (NOP), valid1<=0; pc1 holds.
REQ-020 HOLD, e_f=1: ir1<=buffer, pc1<=pc, valid1<=1, pc<=pc+4; go to FETCH. HOLD, e_f=0: all outputs hold.
REQ-021 Any state, e_f=0 and branch_taken=0: ir1, pc1 and valid1 never change.
REQ-022 branch_taken=1 overrides e_f: ir1<=NOP and valid1<=0 on the same edge; pc<={branch_target[31:2],2'b00}.
REQ-023 branch_taken in FETCH with imem_ack=1: the returned word is dropped; stay in FETCH at the new pc.
REQ-024 branch_taken in FETCH with imem_ack=0: go to DRAIN; the old address is held until imem_ack; then the word is dropped and the state goes to FETCH at the new pc.
REQ-025 branch_taken in HOLD: discard the buffer; go to FETCH.
REQ-026 branch_taken in DRAIN: pc updates to the new target (latest wins); stay in DRAIN until imem_ack.
REQ-027 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.

Reset
REQ-028 rst_n=0 asynchronously forces: pc=RESET_PC, state=FETCH, ir1=0, pc1=0, valid1=0, buffer=0, fetch_count=0.
REQ-029 While rst_n=0, imem_req=0 and imem_addr=RESET_PC.
REQ-030 A reset during a memory transaction abandons the transaction; the memory side tolerates imem_req dropping before imem_ack.
REQ-031 The first request asserts in the first cycle after rst_n rises.

Configuration
REQ-032 Macro FETCH_STAT_EN defined: fetch_count increments on every edge where valid1 is loaded with 1, and saturates at 32'hFFFF_FFFF.
REQ-033 Macro FETCH_STAT_EN undefined: fetch_count is tied to 0 and no counter logic is built.

Verification
REQ-034 Reset release, imem_ack tied 1, e_f=1, rdata=pc^32'hA5A5A5A5 -> pc1 = 0, 4, 8 on consecutive cycles; valid1=1 continuously.
REQ-035 imem_ack=1 while e_f=0 for 3 cycles -> ir1 unchanged; imem_req=0 during HOLD; when e_f rises, the buffered word is delivered with pc1 equal to the stalled pc.
REQ-036 imem_ack delayed 2 cycles with branch_taken=1 and target 32'h0000_0103 in the first wait cycle -> the old word is dropped; next request goes to imem_addr=32'h0000_0100; valid1=0 until it returns.
REQ-037 Two branch_taken pulses in DRAIN (targets 0x200, then 0x300) -> the next request goes to 0x300.
REQ-038 RESET_PC=32'hFFFF_FFFC, zero-wait memory -> imem_addr sequence FFFF_FFFC, 0000_0000; with FETCH_STAT_EN, fetch_count=2 after 2 deliveries; without it, fetch_count=0.
REQ-039 rst_n pulsed low mid-DRAIN -> all outputs reach reset values immediately, with no clock edge required.
